program_sequencer: RTL and testbench

Run controller that sits directly upstream of the instruction-fetch stage and drives its Start / Start_Addr inputs. On a host request it selects one of three program entry points, loads it into the PC, lets the core run until the decoder reports a halt instruction, then signals completion with a four-phase Req/Done handshake. It also reports the run length in cycles and the PC at which the program halted.

---
 rtl/seq_pkg.sv | 17 +
 rtl/sat_counter.sv | 34 +++
 rtl/program_sequencer.sv | 117 +++++++++++
 tb/tb_program_sequencer.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/seq_pkg.sv
// Shared types and constants for the program sequencer: FSM states and program entry points.
package seq_pkg;

    localparam int unsigned NUM_PROGS = 3;

    localparam logic [7:0] PROG0_ADDR = 8'h00;
    localparam logic [7:0] PROG1_ADDR = 8'h40;
    localparam logic [7:0] PROG2_ADDR = 8'h80;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } seq_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear and enable that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         en_i,
    output logic [W-1:0] count_o
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clr_i) begin
            count_d = '0;
        end else if (en_i && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/program_sequencer.sv
// Run controller ahead of instruction fetch: picks an entry point, holds the PC there until
// started, runs until the decoder flags a halt, then completes a four-phase Req/Done handshake.
module program_sequencer
    import seq_pkg::*;
#(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned CYC_W  = 16
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              Req,
    input  logic [1:0]        Prog_Sel,
    input  logic              Halt,
    input  logic [ADDR_W-1:0] PC,
    output logic              Start,
    output logic [ADDR_W-1:0] Start_Addr,
    output logic              Busy,
    output logic              Done,
    output logic              Err,
    output logic [CYC_W-1:0]  Cycle_Count,
    output logic [ADDR_W-1:0] Halt_PC
);

    seq_state_e        state_q, state_d;
    logic [1:0]        sel_q, sel_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] halt_pc_q, halt_pc_d;
    logic              sel_valid_c;
    logic              cnt_clr_c;
    logic              cnt_en_c;

    assign sel_valid_c = (Prog_Sel < 2'(NUM_PROGS));

    always_comb begin
        state_d   = state_q;
        sel_d     = sel_q;
        err_d     = err_q;
        halt_pc_d = halt_pc_q;
        cnt_clr_c = 1'b0;
        cnt_en_c  = 1'b0;

        if (!Req) begin
            err_d = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (Req && sel_valid_c) begin
                    sel_d     = Prog_Sel;
                    cnt_clr_c = 1'b1;
                    state_d   = LOAD;
                end else if (Req) begin
                    err_d = 1'b1;
                end
            end
            LOAD: begin
                state_d = RUN;
            end
            RUN: begin
                cnt_en_c = 1'b1;
                if (Halt) begin
                    halt_pc_d = PC;
                    state_d   = DONE;
                end
            end
            DONE: begin
                if (!Req) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q   <= IDLE;
            sel_q     <= 2'd0;
            err_q     <= 1'b0;
            halt_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            sel_q     <= sel_d;
            err_q     <= err_d;
            halt_pc_q <= halt_pc_d;
        end
    end

    // Entry table indexed by the latched select, so Start_Addr only moves on acceptance.
    always_comb begin
        Start_Addr = ADDR_W'(PROG0_ADDR);
        case (sel_q)
            2'd1:    Start_Addr = ADDR_W'(PROG1_ADDR);
            2'd2:    Start_Addr = ADDR_W'(PROG2_ADDR);
            default: Start_Addr = ADDR_W'(PROG0_ADDR);
        endcase
    end

    sat_counter #(
        .W (CYC_W)
    ) u_cycle_cnt (
        .clk_i   (CLK),
        .rst_i   (Reset),
        .clr_i   (cnt_clr_c),
        .en_i    (cnt_en_c),
        .count_o (Cycle_Count)
    );

    assign Start   = (state_q != RUN);
    assign Busy    = (state_q == LOAD) || (state_q == RUN);
    assign Done    = (state_q == DONE);
    assign Err     = err_q;
    assign Halt_PC = halt_pc_q;

endmodule

// File: tb/tb_program_sequencer.sv
// Directed bench for program_sequencer, plus a narrow-counter instance for saturation.
module tb_program_sequencer;

    logic        CLK;
    logic        Reset;
    logic        Req;
    logic [1:0]  Prog_Sel;
    logic        Halt;
    logic [7:0]  PC;
    logic        Start;
    logic [7:0]  Start_Addr;
    logic        Busy;
    logic        Done;
    logic        Err;
    logic [15:0] Cycle_Count;
    logic [7:0]  Halt_PC;

    logic        req4;
    logic        halt4;
    logic        start4;
    logic [7:0]  start_addr4;
    logic        busy4;
    logic        done4;
    logic        err4;
    logic [3:0]  cyc4;
    logic [7:0]  halt_pc4;

    int checks;
    int failures;

    program_sequencer #(.ADDR_W(8), .CYC_W(16)) dut (
        .CLK(CLK), .Reset(Reset), .Req(Req), .Prog_Sel(Prog_Sel), .Halt(Halt), .PC(PC),
        .Start(Start), .Start_Addr(Start_Addr), .Busy(Busy), .Done(Done), .Err(Err),
        .Cycle_Count(Cycle_Count), .Halt_PC(Halt_PC)
    );

    program_sequencer #(.ADDR_W(8), .CYC_W(4)) dut4 (
        .CLK(CLK), .Reset(Reset), .Req(req4), .Prog_Sel(2'd2), .Halt(halt4), .PC(8'h9A),
        .Start(start4), .Start_Addr(start_addr4), .Busy(busy4), .Done(done4), .Err(err4),
        .Cycle_Count(cyc4), .Halt_PC(halt_pc4)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1; Req = 1'b0; Prog_Sel = 2'd0; Halt = 1'b0; PC = 8'h00;
        req4 = 1'b0; halt4 = 1'b0;
        tick(); tick();
        Reset = 1'b0;
        repeat (5) tick();
        checks++;
        if (Start !== 1'b1) begin failures++; $display("FAIL reset_start got=%b exp=1", Start); end
        checks++;
        if (Start_Addr !== 8'h00) begin failures++; $display("FAIL reset_addr got=%h exp=00", Start_Addr); end
        checks++;
        if ({Busy, Done, Err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {Busy, Done, Err}); end
        checks++;
        if (Cycle_Count !== 16'd0 || Halt_PC !== 8'h00) begin
            failures++; $display("FAIL reset_cnt got=%0d/%h exp=0/00", Cycle_Count, Halt_PC);
        end
    endtask

    task automatic test_run_sel1();
        int low_cnt;
        low_cnt = 0;
        Prog_Sel = 2'd1; Req = 1'b1;
        tick();
        checks++;
        if ({Busy, Start, Done} !== 3'b110 || Start_Addr !== 8'h40) begin
            failures++; $display("FAIL load_phase got=%b addr=%h exp=110 addr=40", {Busy, Start, Done}, Start_Addr);
        end
        tick();
        for (int k = 1; k <= 4; k++) begin
            if (Start === 1'b0) low_cnt++;
            PC = 8'h40 + 8'(k - 1);
            Halt = (k == 4);
            tick();
        end
        Halt = 1'b0;
        if (Start === 1'b0) low_cnt++;
        checks++;
        if (low_cnt != 4) begin failures++; $display("FAIL start_low_cycles got=%0d exp=4", low_cnt); end
        checks++;
        if (Cycle_Count !== 16'd4) begin failures++; $display("FAIL run_count got=%0d exp=4", Cycle_Count); end
        checks++;
        if (Halt_PC !== 8'h43) begin failures++; $display("FAIL run_halt_pc got=%h exp=43", Halt_PC); end
        checks++;
        if ({Done, Busy, Start} !== 3'b101) begin failures++; $display("FAIL done_flags got=%b exp=101", {Done, Busy, Start}); end
        Req = 1'b0;
        tick();
        checks++;
        if (Done !== 1'b0 || Busy !== 1'b0) begin failures++; $display("FAIL done_drop got=%b%b exp=00", Done, Busy); end
        checks++;
        if (Cycle_Count !== 16'd4) begin failures++; $display("FAIL count_hold got=%0d exp=4", Cycle_Count); end
    endtask

    task automatic test_err();
        Prog_Sel = 2'd3; Req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if ({Err, Busy, Start, Done} !== 4'b1010) begin
                failures++; $display("FAIL err_hold cyc=%0d got=%b exp=1010", i, {Err, Busy, Start, Done});
            end
        end
        Req = 1'b0;
        tick();
        checks++;
        if (Err !== 1'b0) begin failures++; $display("FAIL err_clear got=%b exp=0", Err); end
    endtask

    task automatic test_halt_in_load();
        Prog_Sel = 2'd2; Req = 1'b1; Halt = 1'b1; PC = 8'h11;
        tick();
        PC = 8'h80;
        tick();
        checks++;
        if ({Busy, Start, Done} !== 3'b100) begin failures++; $display("FAIL load_ignores_halt got=%b exp=100", {Busy, Start, Done}); end
        PC = 8'h80;
        tick();
        Halt = 1'b0;
        checks++;
        if (Done !== 1'b1 || Cycle_Count !== 16'd1) begin
            failures++; $display("FAIL first_run_halt got=%b/%0d exp=1/1", Done, Cycle_Count);
        end
        checks++;
        if (Halt_PC !== 8'h80 || Start_Addr !== 8'h80) begin
            failures++; $display("FAIL first_run_pc got=%h/%h exp=80/80", Halt_PC, Start_Addr);
        end
    endtask

    task automatic test_no_retrigger();
        repeat (5) tick();
        checks++;
        if ({Done, Busy, Start} !== 3'b101 || Cycle_Count !== 16'd1) begin
            failures++; $display("FAIL no_retrigger got=%b/%0d exp=101/1", {Done, Busy, Start}, Cycle_Count);
        end
        Req = 1'b0;
        tick();
        checks++;
        if (Done !== 1'b0) begin failures++; $display("FAIL retrigger_release got=%b exp=0", Done); end
    endtask

    task automatic test_sel_change_in_run();
        Prog_Sel = 2'd0; Req = 1'b1;
        tick();
        Prog_Sel = 2'd2;
        tick();
        Req = 1'b0;
        tick();
        checks++;
        if (Start_Addr !== 8'h00 || Busy !== 1'b1 || Start !== 1'b0) begin
            failures++; $display("FAIL sel_change_run got=%h/%b%b exp=00/10", Start_Addr, Busy, Start);
        end
        PC = 8'h01; Halt = 1'b1;
        tick();
        Halt = 1'b0;
        checks++;
        if (Cycle_Count !== 16'd2 || Halt_PC !== 8'h01 || Done !== 1'b1) begin
            failures++; $display("FAIL sel_change_done got=%0d/%h/%b exp=2/01/1", Cycle_Count, Halt_PC, Done);
        end
        tick();
        checks++;
        if (Done !== 1'b0 || Start_Addr !== 8'h00) begin
            failures++; $display("FAIL sel_change_idle got=%b/%h exp=0/00", Done, Start_Addr);
        end
    endtask

    task automatic test_reset_mid_run();
        Prog_Sel = 2'd1; Req = 1'b1;
        tick(); tick(); tick(); tick();
        checks++;
        if (Busy !== 1'b1 || Cycle_Count !== 16'd2) begin
            failures++; $display("FAIL pre_reset_run got=%b/%0d exp=1/2", Busy, Cycle_Count);
        end
        #2 Reset = 1'b1;
        #1;
        checks++;
        if ({Start, Busy, Done, Err} !== 4'b1000 || Start_Addr !== 8'h00 || Cycle_Count !== 16'd0) begin
            failures++; $display("FAIL async_reset got=%b/%h/%0d exp=1000/00/0", {Start, Busy, Done, Err}, Start_Addr, Cycle_Count);
        end
        Reset = 1'b0; Req = 1'b0;
        tick();
    endtask

    task automatic test_saturate();
        req4 = 1'b1;
        tick(); tick();
        for (int k = 1; k <= 20; k++) begin
            tick();
            if (k == 14 || k == 15 || k == 20) begin
                checks++;
                if (cyc4 !== ((k >= 15) ? 4'hF : 4'(k)) || busy4 !== 1'b1) begin
                    failures++; $display("FAIL sat_count k=%0d got=%h/%b exp=%h/1", k, cyc4, busy4, (k >= 15) ? 4'hF : 4'(k));
                end
            end
        end
        halt4 = 1'b1;
        tick();
        halt4 = 1'b0; req4 = 1'b0;
        checks++;
        if (done4 !== 1'b1 || cyc4 !== 4'hF || halt_pc4 !== 8'h9A) begin
            failures++; $display("FAIL sat_done got=%b/%h/%h exp=1/f/9a", done4, cyc4, halt_pc4);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_run_sel1();
        test_err();
        test_halt_in_load();
        test_no_retrigger();
        test_sel_change_in_run();
        test_reset_mid_run();
        test_saturate();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
